// File: rtl/signed_mult_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : signed_mult_sequencer_if
// Description : Operand/product handshake bundle for signed_mult_sequencer.
//               The master is the operand source and product consumer.
//               The slave is the sequencer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface signed_mult_sequencer_if #(
    parameter int W = 4
);
    logic           abort;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    modport master (
        output abort, in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  abort, in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface
`default_nettype wire

// File: rtl/signed_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : signed_mult_sequencer
// Description : Sequential signed W x W multiplier. It adds one partial-product
//               row per cycle, LSB row first. The MSB row is subtracted to
//               correct for the two's-complement sign weight of b. The 2W-bit
//               product is held on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_mult_sequencer #(
    parameter int W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    signed_mult_sequencer_if.slave  bus
);
    localparam int              CW     = (W > 2) ? $clog2(W) : 1;
    localparam int              PW     = 2 * W;
    localparam logic [CW-1:0]   C_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   product_q, product_d;

    logic [PW-1:0]   row_w;
    logic [PW-1:0]   term_w;
    logic [PW-1:0]   sum_w;

    // Current partial-product row and running sum; the MSB row carries weight -2^(W-1)
    always_comb begin
        row_w  = b_q[cnt_q] ? {{W{a_q[W-1]}}, a_q} : '0;
        term_w = row_w << cnt_q;
        sum_w  = (cnt_q == C_LAST) ? (acc_q - term_w) : (acc_q + term_w);
    end

    // Next-state and datapath control; abort overrides every handshake
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        product_d = product_q;

        if (bus.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = S_ACC;
                    end
                end
                S_ACC: begin
                    acc_d = sum_w;
                    if (cnt_q == C_LAST) begin
                        product_d = sum_w;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_ACC) || (state_q == S_DONE);
    assign bus.product   = product_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_mult_sequencer
// Description : Self-checking bench for signed_mult_sequencer at W=4 and W=8.
//               Expected products come from plain signed integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_mult_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    signed_mult_sequencer_if #(.W(4)) bus4 ();
    signed_mult_sequencer_if #(.W(8)) bus8 ();

    signed_mult_sequencer #(.W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    signed_mult_sequencer #(.W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y);
        int ix, iy;
        ix = $signed(x);
        iy = $signed(y);
        return 8'(ix * iy);
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
        int ix, iy;
        ix = $signed(x);
        iy = $signed(y);
        return 16'(ix * iy);
    endfunction

    // Entered at a falling edge with the DUT idle; returns at a falling edge.
    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic rdy,
                       output logic [7:0] prod, output int lat);
        bus4.a         = av;
        bus4.b         = bv;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = rdy;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        prod = bus4.product;
        if (rdy) @(negedge clk);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                       output logic [15:0] prod, output int lat);
        bus8.a         = av;
        bus8.b         = bv;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        prod = bus8.product;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [5];
        logic [7:0]  p4;
        logic [15:0] p8;
        int          lat;
        int          acc_t [$];
        int          overlap;
        int          period;
        logic [7:0]  ra, rb;

        tbl[0] = '{4'd3,  4'd5,  8'h0F};
        tbl[1] = '{4'hD,  4'd5,  8'hF1};
        tbl[2] = '{4'h8,  4'd7,  8'hC8};
        tbl[3] = '{4'h8,  4'h8,  8'h40};
        tbl[4] = '{4'hF,  4'hF,  8'h01};

        rst_n = 1'b0;
        bus4.abort = 1'b0; bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
        bus8.abort = 1'b0; bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_in_ready",  32'(bus4.in_ready),  32'd1);
        check("reset_out_valid", 32'(bus4.out_valid), 32'd0);
        check("reset_busy",      32'(bus4.busy),      32'd0);
        check("reset_product",   32'(bus4.product),   32'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table of basic products
        for (int i = 0; i < 5; i++) begin
            op4(tbl[i].a, tbl[i].b, 1'b1, p4, lat);
            check($sformatf("table_prod_%0d", i), 32'(p4), 32'(tbl[i].exp));
            check($sformatf("table_lat_%0d", i), 32'(lat), 32'd4);
        end

        // Exhaustive W=4 sweep
        for (int i = 0; i < 256; i++) begin
            op4(4'(i >> 4), 4'(i), 1'b1, p4, lat);
            check($sformatf("exh_%0d_%0d", i >> 4, i & 15), 32'(p4), 32'(ref4(4'(i >> 4), 4'(i))));
        end

        // Back-to-back period with in_valid held high
        overlap = 0;
        bus4.a = 4'd3; bus4.b = 4'd5; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus4.in_ready) acc_t.push_back(c);
            if (bus4.in_ready && bus4.out_valid) overlap++;
            @(negedge clk);
        end
        bus4.in_valid = 1'b0;
        for (int k = 0; k < 20 && !bus4.in_ready; k++) @(negedge clk);
        period = (acc_t.size() >= 3) ? (acc_t[2] - acc_t[1]) : -1;
        check("b2b_period", 32'(period), 32'd6);
        check("b2b_overlap", 32'(overlap), 32'd0);

        // Backpressure: result frozen, new operands ignored
        op4(4'd7, 4'hF, 1'b0, p4, lat);
        check("bp_prod", 32'(p4), 32'hF9);
        for (int c = 0; c < 10; c++) begin
            bus4.a = 4'd1; bus4.b = 4'd1; bus4.in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("bp_hold_prod_%0d", c), 32'(bus4.product), 32'hF9);
            check($sformatf("bp_hold_valid_%0d", c), 32'(bus4.out_valid), 32'd1);
            check($sformatf("bp_hold_ready_%0d", c), 32'(bus4.in_ready), 32'd0);
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(bus4.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus4.in_ready), 32'd1);
        check("bp_release_prod", 32'(bus4.product), 32'hF9);

        // Abort in ACC at cnt=2, then a clean operation
        bus4.a = 4'd7; bus4.b = 4'd7; bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus4.abort = 1'b1;
        @(negedge clk);
        bus4.abort = 1'b0;
        check("abort_acc_ready", 32'(bus4.in_ready), 32'd1);
        check("abort_acc_busy", 32'(bus4.busy), 32'd0);
        op4(4'd2, 4'd2, 1'b1, p4, lat);
        check("after_abort_prod", 32'(p4), 32'h04);
        check("after_abort_lat", 32'(lat), 32'd4);

        // Abort in DONE together with out_ready
        op4(4'hE, 4'd3, 1'b0, p4, lat);
        check("abort_done_prod", 32'(p4), 32'hFA);
        bus4.abort = 1'b1;
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.abort = 1'b0;
        check("abort_done_ready", 32'(bus4.in_ready), 32'd1);
        check("abort_done_valid", 32'(bus4.out_valid), 32'd0);
        check("abort_done_busy", 32'(bus4.busy), 32'd0);
        check("abort_done_keep", 32'(bus4.product), 32'hFA);

        // W=8 directed and randomized
        op8(8'h80, 8'h80, p8, lat);
        check("w8_prod_min_min", 32'(p8), 32'h4000);
        check("w8_lat", 32'(lat), 32'd8);
        op8(8'd127, 8'h80, p8, lat);
        check("w8_prod_max_min", 32'(p8), 32'hC080);
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(ra, rb, p8, lat);
            check($sformatf("w8_rand_%0d", i), 32'(p8), 32'(ref8(ra, rb)));
        end

        // Asynchronous reset in the middle of ACC
        bus4.a = 4'd5; bus4.b = 4'd3; bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(bus4.in_ready), 32'd1);
        check("rst_mid_valid", 32'(bus4.out_valid), 32'd0);
        check("rst_mid_busy", 32'(bus4.busy), 32'd0);
        check("rst_mid_prod", 32'(bus4.product), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/signed_mult_sequencer.md
# signed_mult_sequencer

Sequential controller for the signed (two's-complement) W×W multiplier datapath. It accepts one operand pair through a valid/ready handshake and generates one partial-product row per cycle, LSB row first. It accumulates the rows with sign-correct weighting, the MSB row being subtracted, and presents the 2W-bit product on a valid/ready output port that holds under backpressure. It sits between the operand source and the consumer of products. It replaces the fully parallel reduction tree where area matters more than latency.

## Interface
- `W`, default 4: operand width in bits; the product is 2W bits. Legal range is W ≥ 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `abort`  input  1  synchronous flush to IDLE; higher priority than every handshake.
- `in_valid`  input  1  an operand pair is offered.
- `in_ready`  output  1  high only in IDLE.
- `a`  input  W  multiplicand, signed.
- `b`  input  W  multiplier, signed.
- `out_valid`  output  1  product available; high only in DONE.
- `out_ready`  input  1  consumer accepts the product.
- `product`  output  2W  signed a*b; registered.
- `busy`  output  1  high in ACC and DONE.

## Operation
- **State machine.** States are IDLE, ACC and DONE. Registers: `a_r` (W), `b_r` (W), `cnt` (log2 W bits, minimum 1), `acc` (2W), and `product` (2W, registered).
- **IDLE.**
  - Outputs: in_ready=1, out_valid=0, busy=0.
  - On in_valid & in_ready: capture a_r=a and b_r=b, clear acc=0 and cnt=0, go to ACC.
- **ACC.** In each cycle:
  - Form row = b_r[cnt] ? sext(a_r) : 0, sign-extended to 2W bits.
  - If cnt < W-1: acc += row << cnt.
  - If cnt = W-1: acc −= row << (W-1). This subtraction is the MSB-row sign correction. It is equivalent to adding the inverted row plus the correction constant.
  - All arithmetic is modulo 2^(2W). No overflow is possible, because (−2^(W-1))² = 2^(2W-2) fits in 2W signed bits.
  - When cnt = W-1: load product with the final sum (acc plus this cycle's term) and go to DONE. Otherwise cnt += 1.
- **DONE.**
  - Outputs: out_valid=1, busy=1.
  - product, a_r and b_r are held stable.
  - On out_ready: go to IDLE. product keeps its value until the next load; only out_valid drops.
- **abort.**
  - In any state, abort=1 at an edge forces IDLE and clears cnt and acc. The product register is left as-is.
  - A pending in_valid on that edge is not accepted.
  - An abort in DONE discards the result; no handshake completes.
- **Blocking.** in_valid while busy is ignored, because in_ready=0. The source must hold a and b until in_ready.

## Timing
- **Reset values** (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, acc=0, cnt=0, a_r=0, b_r=0.
- **Latency.**
  - The accepting edge is edge 0.
  - ACC runs for edges 1…W.
  - out_valid is high in the cycle after edge W, i.e. W cycles after acceptance.
- **Throughput.** With out_ready held at 1, the block handles one product every W+2 cycles: accept, W accumulate cycles, then the output handshake edge.
- **Back-to-back.** The next operand pair can be accepted no earlier than the edge after the output handshake. in_ready and out_valid are never high together.
- **Backpressure.** While out_valid=1 and out_ready=0, all outputs are frozen for an unbounded time.
- **Reset mid-operation.** Reset returns to IDLE immediately, asynchronously. The operation is lost and product reads 0.
- **Output timing.** All outputs come directly from registers or decode of the state register. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- **Reset.** W=4; assert rst_n=0 mid-ACC → in_ready=1, out_valid=0, busy=0 and product=8'h00 immediately, without waiting for a clock edge.
- **Basic products.** W=4, out_ready=1: a=3,b=5 → product=8'h0F; a=−3,b=5 → 8'hF1; a=−8,b=7 → 8'hC8; a=−8,b=−8 → 8'h40; a=−1,b=−1 → 8'h01. Each must have out_valid exactly 4 cycles after acceptance.
- **Exhaustive.** Run all 256 pairs at W=4 against a signed reference model. Also check the back-to-back period of 6 cycles with in_valid held at 1.
- **Backpressure.** a=7,b=−1, with out_ready held at 0 for 10 cycles → product=8'hF9 is stable throughout with out_valid=1, in_ready stays 0, and new in_valid is ignored. The result is released on the first out_ready.
- **Abort.** Assert abort in ACC with cnt=2 → IDLE on the next edge. Then a=2,b=2 → product=8'h04, with no residue from the aborted operation. Assert abort in DONE together with out_ready=1 → no handshake, and IDLE.
- **Width parameter.** W=8: a=−128,b=−128 → 16'h4000; a=127,b=−128 → 16'hC080. out_valid must appear 8 cycles after acceptance.
